fetch_pc_sequencer: RTL and testbench
=====================================

# fetch_pc_sequencer

Sequences the program counter and instruction fetch for the RISC-V core. It owns the PC register and drives the instruction memory request/acknowledge handshake. It presents fetched instructions to decode through a valid/ready handshake, and it applies branch/jump redirects and halts. It sits between the instruction memory and the decode stage and replaces free-running PC+4 sequencing with a stall- and redirect-aware controller.

## Interface
- RESET_PC, 32'h0000_0000, first fetch address after reset
- TRAP_PC, 32'h0000_0100, fetch address after a misaligned redirect (only used with FETCH_MISALIGN_CHECK_EN)

Ports:
- clk  in  1  rising-edge clock; the block has one clock
- rst_n  in  1  synchronous, active-low reset
- imem_req  out  1  one-cycle request pulse; imem_addr is valid with it
- imem_addr  out  32  word-aligned fetch address
- imem_ack  in  1  one pulse per request, arriving 1 or more cycles after imem_req; imem_rdata is valid with it
- imem_rdata  in  32  instruction word
- id_valid  out  1  instruction available to decode
- id_instr  out  32  instruction word
- id_pc  out  32  address of id_instr
- id_pc_plus4  out  32  id_pc + 4, modulo 2^32
- id_ready  in  1  decode accepts; transfer happens when id_valid && id_ready
- redirect_valid  in  1  taken branch/jump, one-cycle pulse
- redirect_pc  in  32  target address
- halt  in  1  level; while high, no new request is issued
- misalign_trap  out  1  one-cycle pulse on a misaligned redirect; tied 0 when the feature is compiled out

## Operation
- States: REQ, WAIT, HOLD, HALT.
- REQ: assert imem_req with imem_addr = pc, then go to WAIT. If halt is high on entry, go to HALT instead and do not request.
- WAIT: on imem_ack, latch imem_rdata, pc, and pc+4 into the output buffer, then go to HOLD.
- HOLD: id_valid = 1. On a handshake, pc <= pc+4, then go to REQ, or to HALT if halt is high.
- HALT: no requests are issued. When halt drops, go to REQ.
- Redirect in REQ or HALT: pc <= redirect_pc, then go to REQ.
- Redirect in HOLD: the buffer is flushed (id_valid drops next cycle) unless a handshake occurs in the same cycle. A handshake in that cycle is honored. Either way pc <= redirect_pc and the next state is REQ.
- Redirect in WAIT: set the kill flag and pc <= redirect_pc. The pending imem_ack is consumed and discarded, and the state then goes to REQ. A second redirect before that ack overwrites pc only.
- The kill flag clears on the discarded ack or on reset.
- imem_addr[1:0] is always 2'b00.
- PC arithmetic is 32-bit unsigned and wraps: 32'hFFFF_FFFC + 4 = 32'h0000_0000.

## Timing
- Reset values (rst_n low at a clock edge):
  - state = REQ, pc = RESET_PC, kill = 0
  - imem_req = 0, imem_addr = RESET_PC
  - id_valid = 0, id_instr = 0, id_pc = 0, id_pc_plus4 = 0
  - misalign_trap = 0
- First imem_req: the first cycle with rst_n high.
- imem_ack in cycle N gives id_valid in cycle N+1 (registered).
- A handshake in cycle M gives the next imem_req in cycle M+1.
- Redirect in cycle R (REQ/HOLD/HALT) gives imem_req with redirect_pc in cycle R+1.
- Reset mid-fetch: an outstanding ack arriving after reset release is ignored.
- Handshake rules:
  - id_valid is never dropped without a handshake, except on redirect or reset.
  - id_instr, id_pc and id_pc_plus4 are stable while id_valid && !id_ready.
- Only one fetch is outstanding at a time.

## Configuration
- FETCH_MISALIGN_CHECK_EN defined: a redirect_pc with bits [1:0] != 0 pulses misalign_trap in the redirect cycle and sets pc <= TRAP_PC instead of the target.
- Not defined: redirect_pc[1:0] is forced to 0 and misalign_trap is constant 0.

## Structure
- Shared package holds:
  - state encoding constants: REQ=2'd0, WAIT=2'd1, HOLD=2'd2, HALT=2'd3
  - XLEN = 32
  - default RESET_PC and TRAP_PC
- One sub-module: the existing AdderPC, instantiated for pc+4. It is reused for id_pc_plus4 via the latched value.

## Test plan
- Reset release, 1-cycle memory, id_ready=1 → fetches at 0x0, 0x4, 0x8. id_pc_plus4 = 0x4, 0x8, 0xC.
- id_ready=0 for 5 cycles in HOLD → id_valid, id_instr and id_pc are held constant and there is no imem_req. Raising id_ready gives a request for pc+4 the next cycle.
- Redirect to 0x200 while in WAIT with 3-cycle ack latency → the ack data is not presented, and the next imem_addr is 0x200.
- Redirect to 0x80 in the same cycle as a HOLD handshake at pc 0x10 → the instruction at 0x10 is transferred and the next fetch is 0x80.
- halt high for 4 cycles after a handshake → no imem_req during halt. The request resumes the cycle after halt drops, at the correct pc.
- With FETCH_MISALIGN_CHECK_EN, redirect to 0x102 → misalign_trap pulses and the next fetch is TRAP_PC. Without the macro, the next fetch is 0x100. Separately, pc 0xFFFF_FFFC wraps to fetch 0x0.

Source files
------------

// File: rtl/fetch_pc_sequencer_pkg.sv
// Shared definitions for the fetch PC sequencer: datapath width, FSM state
// encoding and the default reset/trap fetch addresses.
package fetch_pc_sequencer_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] RESET_PC = 32'h0000_0000;
  localparam logic [XLEN-1:0] TRAP_PC  = 32'h0000_0100;

  typedef enum logic [1:0] {
    REQ  = 2'd0,
    WAIT = 2'd1,
    HOLD = 2'd2,
    HALT = 2'd3
  } state_e;

endpackage

// File: rtl/fetch_pc_sequencer_if.sv
// Instruction-memory request/ack bus plus the decode valid/ready bus.
// The master side is the sequencer; the slave side is memory and decode.
interface fetch_pc_sequencer_if;
  import fetch_pc_sequencer_pkg::*;

  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_ack;
  logic [XLEN-1:0] imem_rdata;
  logic            id_valid;
  logic [XLEN-1:0] id_instr;
  logic [XLEN-1:0] id_pc;
  logic [XLEN-1:0] id_pc_plus4;
  logic            id_ready;

  modport master (
    output imem_req, imem_addr, id_valid, id_instr, id_pc, id_pc_plus4,
    input  imem_ack, imem_rdata, id_ready
  );

  modport slave (
    input  imem_req, imem_addr, id_valid, id_instr, id_pc, id_pc_plus4,
    output imem_ack, imem_rdata, id_ready
  );

endinterface

// File: rtl/fetch_pc_sequencer_adder_pc.sv
// PC incrementer: next sequential instruction address, wrapping modulo 2^32.
module fetch_pc_sequencer_adder_pc
  import fetch_pc_sequencer_pkg::*;
(
  input  logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_plus4
);

  assign pc_plus4 = pc + 32'd4;

endmodule

// File: rtl/fetch_pc_sequencer.sv
// Stall- and redirect-aware PC sequencer between instruction memory and decode.
// Optional feature: FETCH_MISALIGN_CHECK_EN traps misaligned redirects to TRAP_PC.
module fetch_pc_sequencer
  import fetch_pc_sequencer_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  fetch_pc_sequencer_if.master bus,
  input  logic                 redirect_valid,
  input  logic [XLEN-1:0]      redirect_pc,
  input  logic                 halt,
  output logic                 misalign_trap
);

  state_e          state_r, state_s;
  logic [XLEN-1:0] pc_r, pc_s, pc_plus4_s, target_s;
  logic            kill_r, kill_s;
  logic            valid_r, valid_s, load_s;
  logic [XLEN-1:0] instr_r, id_pc_r, id_pc4_r;
  logic            trap_s, hs_s;

  fetch_pc_sequencer_adder_pc u_adder_pc (
    .pc       (pc_r),
    .pc_plus4 (pc_plus4_s)
  );

`ifdef FETCH_MISALIGN_CHECK_EN
  assign trap_s   = redirect_valid && (redirect_pc[1:0] != 2'b00);
  assign target_s = trap_s ? TRAP_PC : redirect_pc;
`else
  assign trap_s   = 1'b0;
  assign target_s = redirect_pc & ~32'h0000_0003;
`endif

  assign hs_s          = valid_r && bus.id_ready;
  assign misalign_trap = rst_n && trap_s;

  // A redirect in REQ suppresses the request so no stale fetch goes out.
  assign bus.imem_req  = rst_n && (state_r == REQ) && !halt && !redirect_valid;
  assign bus.imem_addr = {pc_r[XLEN-1:2], 2'b00};

  assign bus.id_valid    = valid_r;
  assign bus.id_instr    = instr_r;
  assign bus.id_pc       = id_pc_r;
  assign bus.id_pc_plus4 = id_pc4_r;

  // Next-state, next-pc and buffer control
  always_comb begin
    state_s = state_r;
    pc_s    = pc_r;
    kill_s  = kill_r;
    valid_s = valid_r;
    load_s  = 1'b0;
    case (state_r)
      REQ: begin
        if (redirect_valid) begin
          pc_s    = target_s;
          state_s = REQ;
        end else if (halt) begin
          state_s = HALT;
        end else begin
          state_s = WAIT;
        end
      end
      WAIT: begin
        if (redirect_valid) begin
          pc_s = target_s;
        end else begin
          pc_s = pc_r;
        end
        if (bus.imem_ack) begin
          kill_s = 1'b0;
          if (kill_r || redirect_valid) begin
            state_s = REQ;
          end else begin
            load_s  = 1'b1;
            valid_s = 1'b1;
            state_s = HOLD;
          end
        end else begin
          kill_s  = kill_r || redirect_valid;
          state_s = WAIT;
        end
      end
      HOLD: begin
        // A handshake coinciding with a redirect still transfers the word.
        if (redirect_valid) begin
          pc_s    = target_s;
          valid_s = 1'b0;
          state_s = REQ;
        end else if (hs_s) begin
          pc_s    = pc_plus4_s;
          valid_s = 1'b0;
          state_s = halt ? HALT : REQ;
        end else begin
          state_s = HOLD;
        end
      end
      HALT: begin
        if (redirect_valid) begin
          pc_s    = target_s;
          state_s = REQ;
        end else if (!halt) begin
          state_s = REQ;
        end else begin
          state_s = HALT;
        end
      end
      default: begin
        state_s = REQ;
      end
    endcase
  end

  // Control state: FSM, pc, kill flag and output-valid
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= REQ;
      pc_r    <= RESET_PC;
      kill_r  <= 1'b0;
      valid_r <= 1'b0;
    end else begin
      state_r <= state_s;
      pc_r    <= pc_s;
      kill_r  <= kill_s;
      valid_r <= valid_s;
    end
  end

  // Decode-facing output buffer, loaded only by a non-discarded ack
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      instr_r  <= 32'h0000_0000;
      id_pc_r  <= 32'h0000_0000;
      id_pc4_r <= 32'h0000_0000;
    end else if (load_s) begin
      instr_r  <= bus.imem_rdata;
      id_pc_r  <= pc_r;
      id_pc4_r <= pc_plus4_s;
    end else begin
      instr_r  <= instr_r;
      id_pc_r  <= id_pc_r;
      id_pc4_r <= id_pc4_r;
    end
  end

endmodule

// File: tb/tb_fetch_pc_sequencer.sv
// Directed self-checking bench for fetch_pc_sequencer with a latency-programmable
// instruction memory model; expectations depend on FETCH_MISALIGN_CHECK_EN.
module tb_fetch_pc_sequencer;

  localparam logic [31:0] MAGIC = 32'hA5A5_5A5A;
`ifdef FETCH_MISALIGN_CHECK_EN
  localparam logic EXP_TRAP = 1'b1;
`else
  localparam logic EXP_TRAP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        halt = 1'b0;
  logic        misalign_trap;

  int n_tests = 0;
  int n_fail  = 0;
  int mem_lat = 1;
  int mem_cnt = 0;
  logic [31:0] mem_addr = 32'h0;

  fetch_pc_sequencer_if bus ();

  fetch_pc_sequencer dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .bus            (bus),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halt           (halt),
    .misalign_trap  (misalign_trap)
  );

  always #5 clk = ~clk;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic [31:0] a, input logic [31:0] a4);
    chk1 (tag, bus.id_valid, 1'b1);
    chk32(tag, bus.id_pc, a);
    chk32(tag, bus.id_pc_plus4, a4);
    chk32(tag, bus.id_instr, a ^ MAGIC);
  endtask

  // Instruction memory: samples requests mid-cycle, answers mem_lat cycles later
  initial begin
    bus.imem_ack   = 1'b0;
    bus.imem_rdata = 32'h0;
    forever begin
      @(negedge clk);
      if (mem_cnt != 0) begin
        mem_cnt = mem_cnt - 1;
        bus.imem_ack   = (mem_cnt == 0);
        bus.imem_rdata = (mem_cnt == 0) ? (mem_addr ^ MAGIC) : 32'h0;
      end else begin
        bus.imem_ack   = 1'b0;
        bus.imem_rdata = 32'h0;
      end
      if (bus.imem_req === 1'b1) begin
        n_tests++;
        assert (mem_cnt == 0) else begin
          n_fail++;
          $error("FAIL one_outstanding: observed %0d pending expected 0", mem_cnt);
        end
        mem_cnt  = mem_lat;
        mem_addr = bus.imem_addr;
      end
    end
  end

  initial begin
    bus.id_ready = 1'b0;
    repeat (3) nxt();
    #1;
    chk1 ("rst_req", bus.imem_req, 1'b0);
    chk32("rst_addr", bus.imem_addr, 32'h0);
    chk1 ("rst_valid", bus.id_valid, 1'b0);
    chk32("rst_instr", bus.id_instr, 32'h0);
    chk32("rst_pc", bus.id_pc, 32'h0);
    chk32("rst_pc4", bus.id_pc_plus4, 32'h0);
    chk1 ("rst_trap", misalign_trap, 1'b0);

    // Sequential fetch with 1-cycle memory and decode always ready
    rst_n = 1'b1;
    bus.id_ready = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk1 ("seq_req", bus.imem_req, 1'b1);
      chk32("seq_addr", bus.imem_addr, 32'(i * 4));
      nxt(); #1;
      chk1 ("seq_wait_req", bus.imem_req, 1'b0);
      chk1 ("seq_wait_valid", bus.id_valid, 1'b0);
      nxt(); #1;
      chk_out("seq_out", 32'(i * 4), 32'(i * 4 + 4));
      nxt(); #1;
    end

    // Decode stall for 5 cycles in HOLD
    bus.id_ready = 1'b0;
    chk32("stall_addr", bus.imem_addr, 32'h0000_000C);
    nxt(); #1;
    nxt(); #1;
    for (int k = 0; k < 5; k++) begin
      chk_out("stall_hold", 32'h0000_000C, 32'h0000_0010);
      chk1("stall_noreq", bus.imem_req, 1'b0);
      nxt(); #1;
    end
    bus.id_ready = 1'b1;
    #1;
    chk1("stall_release_valid", bus.id_valid, 1'b1);
    nxt();
    bus.id_ready = 1'b0;
    #1;
    chk1 ("stall_resume_req", bus.imem_req, 1'b1);
    chk32("stall_resume_addr", bus.imem_addr, 32'h0000_0010);

    // Redirect coinciding with a HOLD handshake at 0x10
    nxt(); #1;
    nxt();
    bus.id_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0080;
    #1;
    chk_out("hsredir_xfer", 32'h0000_0010, 32'h0000_0014);
    nxt();
    redirect_valid = 1'b0;
    bus.id_ready = 1'b0;
    mem_lat = 3;
    #1;
    chk1 ("hsredir_flush", bus.id_valid, 1'b0);
    chk1 ("hsredir_req", bus.imem_req, 1'b1);
    chk32("hsredir_addr", bus.imem_addr, 32'h0000_0080);

    // Redirect during WAIT with 3-cycle memory: the late ack is discarded
    nxt();
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0200;
    #1;
    chk1("kill_noreq", bus.imem_req, 1'b0);
    nxt();
    redirect_valid = 1'b0;
    #1;
    chk1("kill_wait_valid", bus.id_valid, 1'b0);
    nxt(); #1;
    chk1("kill_ack_valid", bus.id_valid, 1'b0);
    chk1("kill_ack_noreq", bus.imem_req, 1'b0);
    nxt();
    mem_lat = 1;
    #1;
    chk1 ("kill_discard_valid", bus.id_valid, 1'b0);
    chk1 ("kill_req", bus.imem_req, 1'b1);
    chk32("kill_addr", bus.imem_addr, 32'h0000_0200);

    // Halt raised with a handshake, held 4 more cycles
    nxt(); #1;
    nxt();
    bus.id_ready = 1'b1;
    halt = 1'b1;
    #1;
    chk_out("halt_xfer", 32'h0000_0200, 32'h0000_0204);
    nxt();
    bus.id_ready = 1'b0;
    #1;
    for (int k = 0; k < 4; k++) begin
      chk1("halt_noreq", bus.imem_req, 1'b0);
      chk1("halt_novalid", bus.id_valid, 1'b0);
      nxt(); #1;
    end
    halt = 1'b0;
    #1;
    chk1("halt_drop_noreq", bus.imem_req, 1'b0);
    nxt(); #1;
    chk1 ("halt_resume_req", bus.imem_req, 1'b1);
    chk32("halt_resume_addr", bus.imem_addr, 32'h0000_0204);

    // Misaligned redirect in HOLD
    nxt(); #1;
    nxt(); #1;
    chk32("mis_hold_pc", bus.id_pc, 32'h0000_0204);
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0102;
    #1;
    chk1("mis_trap", misalign_trap, EXP_TRAP);
    nxt();
    redirect_valid = 1'b0;
    #1;
    chk1 ("mis_flush", bus.id_valid, 1'b0);
    chk1 ("mis_req", bus.imem_req, 1'b1);
    chk32("mis_addr", bus.imem_addr, 32'h0000_0100);
    chk1 ("mis_trap_done", misalign_trap, 1'b0);

    // PC wrap from 0xFFFF_FFFC
    nxt(); #1;
    nxt(); #1;
    chk32("wrap_prev_pc", bus.id_pc, 32'h0000_0100);
    redirect_valid = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    nxt();
    redirect_valid = 1'b0;
    #1;
    chk32("wrap_fetch_addr", bus.imem_addr, 32'hFFFF_FFFC);
    nxt(); #1;
    nxt();
    bus.id_ready = 1'b1;
    #1;
    chk_out("wrap_out", 32'hFFFF_FFFC, 32'h0000_0000);
    nxt();
    bus.id_ready = 1'b0;
    #1;
    chk1 ("wrap_req", bus.imem_req, 1'b1);
    chk32("wrap_addr", bus.imem_addr, 32'h0000_0000);

    // Redirect while in REQ
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0040;
    #1;
    chk1("reqredir_noreq", bus.imem_req, 1'b0);
    nxt();
    redirect_valid = 1'b0;
    mem_lat = 3;
    #1;
    chk1 ("reqredir_req", bus.imem_req, 1'b1);
    chk32("reqredir_addr", bus.imem_addr, 32'h0000_0040);

    // Reset mid-fetch: stale ack lands in the first REQ cycle after release
    nxt();
    rst_n = 1'b0;
    nxt();
    mem_lat = 1;
    #1;
    chk1 ("mrst_req", bus.imem_req, 1'b0);
    chk1 ("mrst_valid", bus.id_valid, 1'b0);
    chk32("mrst_addr", bus.imem_addr, 32'h0000_0000);
    nxt();
    rst_n = 1'b1;
    #1;
    chk1 ("mrst_first_req", bus.imem_req, 1'b1);
    chk32("mrst_first_addr", bus.imem_addr, 32'h0000_0000);
    nxt(); #1;
    chk1("mrst_stale_ignored", bus.id_valid, 1'b0);
    nxt(); #1;
    chk_out("mrst_out", 32'h0000_0000, 32'h0000_0004);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1);
  end

endmodule
